// File: rtl/ris_seq_pkg.sv
// Shared definitions for the RIS pattern sequencer.
// Contents: FSM state enum, slave register offsets, CTRL/STATUS bit
// positions, PWM channel count and the NUM_PAT clamp helper.
package ris_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2
  } seq_state_e;

  localparam logic [7:0] REG_CTRL    = 8'h00;
  localparam logic [7:0] REG_STATUS  = 8'h01;
  localparam logic [7:0] REG_NUM_PAT = 8'h02;
  localparam logic [7:0] REG_DWELL   = 8'h03;
  localparam logic [7:0] PAT_BASE    = 8'h80;

  localparam int CTRL_START  = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_STOP   = 2;
  localparam int STATUS_DONE = 8;

  localparam int         NUM_CH  = 9;
  localparam logic [3:0] LAST_CH = 4'd8;

  // Index of the last pattern to play: 0 counts as 1, values above the
  // number of slots are clamped to the slot count.
  function automatic logic [2:0] last_pat_idx(input logic [3:0] raw, input int num_patterns);
    logic [3:0] eff;
    if (raw == 4'd0) begin
      eff = 4'd1;
    end else if (int'(raw) > num_patterns) begin
      eff = 4'(num_patterns);
    end else begin
      eff = raw;
    end
    return 3'(eff - 4'd1);
  endfunction

endpackage

// File: rtl/ris_pattern_ram.sv
// Pattern store: NUM_PATTERNS x 9 channels x RESOLUTION bits.
// Ports: clk; CPU port (cpu_we_i, cpu_pat_i, cpu_ch_i, cpu_wdata_i,
// cpu_rdata_o); sequencer read port (seq_pat_i, seq_ch_i, seq_rdata_o).
// Reads are combinational; out-of-range pattern/channel reads return 0
// and out-of-range writes are dropped.
module ris_pattern_ram
  import ris_seq_pkg::*;
#(
  parameter int RESOLUTION   = 16,
  parameter int NUM_PATTERNS = 8
) (
  input  logic                  clk,
  input  logic                  cpu_we_i,
  input  logic [2:0]            cpu_pat_i,
  input  logic [3:0]            cpu_ch_i,
  input  logic [RESOLUTION-1:0] cpu_wdata_i,
  output logic [RESOLUTION-1:0] cpu_rdata_o,
  input  logic [2:0]            seq_pat_i,
  input  logic [3:0]            seq_ch_i,
  output logic [RESOLUTION-1:0] seq_rdata_o
);

  localparam int DEPTH = NUM_PATTERNS * NUM_CH;
  localparam int IDX_W = $clog2(DEPTH);

  logic [RESOLUTION-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]      cpu_idx_s;
  logic [IDX_W-1:0]      seq_idx_s;
  logic                  cpu_ok_s;
  logic                  seq_ok_s;

  // Flatten (pattern, channel) and range-check both ports.
  always_comb begin
    cpu_ok_s  = (int'(cpu_ch_i) < NUM_CH) && (int'(cpu_pat_i) < NUM_PATTERNS);
    seq_ok_s  = (int'(seq_ch_i) < NUM_CH) && (int'(seq_pat_i) < NUM_PATTERNS);
    cpu_idx_s = IDX_W'(int'(cpu_pat_i) * NUM_CH + int'(cpu_ch_i));
    seq_idx_s = IDX_W'(int'(seq_pat_i) * NUM_CH + int'(seq_ch_i));
  end

  // CPU write port.
  always_ff @(posedge clk) begin
    if (cpu_we_i && cpu_ok_s) begin
      mem_q[cpu_idx_s] <= cpu_wdata_i;
    end
  end

  // Combinational read ports.
  always_comb begin
    if (cpu_ok_s) begin
      cpu_rdata_o = mem_q[cpu_idx_s];
    end else begin
      cpu_rdata_o = {RESOLUTION{1'b0}};
    end
    if (seq_ok_s) begin
      seq_rdata_o = mem_q[seq_idx_s];
    end else begin
      seq_rdata_o = {RESOLUTION{1'b0}};
    end
  end

endmodule

// File: rtl/ris_pattern_sequencer.sv
// Autonomous beam-pattern scheduler for the 9-channel RIS PWM block.
// Ports: clk/reset (async, active-high); Avalon-MM slave s_* for config,
// status and pattern memory; Avalon-MM master m_* writing duty registers
// 0..8 of the PWM wrapper; seq_busy, pattern_idx, frame_done status.
// Each step writes one 9-channel pattern, dwells DWELL cycles, then moves
// to the next pattern (once or looping).
module ris_pattern_sequencer
  import ris_seq_pkg::*;
#(
  parameter int RESOLUTION   = 16,
  parameter int NUM_PATTERNS = 8,
  parameter int DWELL_W      = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_address,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        seq_busy,
  output logic [2:0]  pattern_idx,
  output logic        frame_done
);

  localparam int               PAD_W     = 32 - RESOLUTION;
  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  seq_state_e            state_q;
  logic [2:0]            idx_q;
  logic [2:0]            last_idx_q;
  logic                  loop_q;
  logic                  stop_pend_q;
  logic [DWELL_W-1:0]    dwell_cnt_q;
  logic                  m_write_q;
  logic [3:0]            m_addr_q;
  logic [31:0]           m_wdata_q;
  logic                  busy_q;
  logic                  fd_q;
  logic                  done_q;
  logic [3:0]            num_pat_q;
  logic [DWELL_W-1:0]    dwell_q;
  logic [31:0]           rdata_q;

  logic                  ctrl_wr_s;
  logic                  start_s;
  logic                  stop_s;
  logic                  status_clr_s;
  logic                  pat_wr_s;
  logic                  accept_s;
  logic [DWELL_W-1:0]    dwell_load_s;
  logic [2:0]            wrap_idx_d;
  logic [2:0]            rd_idx_d;
  logic [3:0]            rd_ch_d;
  logic [RESOLUTION-1:0] cpu_rdata_s;
  logic [RESOLUTION-1:0] seq_rdata_s;
  logic [31:0]           rd_mux_s;
  logic                  unused_ok_s;

  assign unused_ok_s = &{1'b0, s_writedata};

  ris_pattern_ram #(
    .RESOLUTION  (RESOLUTION),
    .NUM_PATTERNS(NUM_PATTERNS)
  ) u_ram (
    .clk        (clk),
    .cpu_we_i   (pat_wr_s),
    .cpu_pat_i  (s_address[6:4]),
    .cpu_ch_i   (s_address[3:0]),
    .cpu_wdata_i(s_writedata[RESOLUTION-1:0]),
    .cpu_rdata_o(cpu_rdata_s),
    .seq_pat_i  (rd_idx_d),
    .seq_ch_i   (rd_ch_d),
    .seq_rdata_o(seq_rdata_s)
  );

  // Slave decode and the address of the entry the next issued write needs.
  always_comb begin
    ctrl_wr_s    = s_write && (s_address == REG_CTRL);
    // STOP wins over START in the same write.
    start_s      = ctrl_wr_s && s_writedata[CTRL_START] && !s_writedata[CTRL_STOP];
    stop_s       = ctrl_wr_s && s_writedata[CTRL_STOP];
    status_clr_s = s_write && (s_address == REG_STATUS) && s_writedata[STATUS_DONE];
    pat_wr_s     = s_write && s_address[7];
    accept_s     = m_write_q && !m_waitrequest;
    if (dwell_q == {DWELL_W{1'b0}}) begin
      dwell_load_s = DWELL_ONE;
    end else begin
      dwell_load_s = dwell_q;
    end
    if (idx_q < last_idx_q) begin
      wrap_idx_d = idx_q + 3'd1;
    end else begin
      wrap_idx_d = 3'd0;
    end
    // Memory is read the cycle a channel is launched, so CPU updates to
    // the active pattern reach every channel not yet issued.
    rd_idx_d = 3'd0;
    rd_ch_d  = 4'd0;
    case (state_q)
      ST_LOAD: begin
        rd_idx_d = idx_q;
        rd_ch_d  = m_addr_q + 4'd1;
      end
      ST_DWELL: begin
        rd_idx_d = wrap_idx_d;
        rd_ch_d  = 4'd0;
      end
      default: begin
        rd_idx_d = 3'd0;
        rd_ch_d  = 4'd0;
      end
    endcase
  end

  // Configuration registers written by the CPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_pat_q <= 4'd0;
      dwell_q   <= {DWELL_W{1'b0}};
    end else if (s_write) begin
      if (s_address == REG_NUM_PAT) num_pat_q <= s_writedata[3:0];
      if (s_address == REG_DWELL)   dwell_q   <= s_writedata[DWELL_W-1:0];
    end
  end

  // Sequencer FSM with registered master-port and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      last_idx_q  <= 3'd0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      dwell_cnt_q <= {DWELL_W{1'b0}};
      m_write_q   <= 1'b0;
      m_addr_q    <= 4'd0;
      m_wdata_q   <= 32'd0;
      busy_q      <= 1'b0;
      fd_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (status_clr_s) done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q     <= ST_LOAD;
            busy_q      <= 1'b1;
            idx_q       <= 3'd0;
            loop_q      <= s_writedata[CTRL_LOOP];
            last_idx_q  <= last_pat_idx(num_pat_q, NUM_PATTERNS);
            stop_pend_q <= 1'b0;
            m_write_q   <= 1'b1;
            m_addr_q    <= 4'd0;
            m_wdata_q   <= {{PAD_W{1'b0}}, seq_rdata_s};
          end
        end
        ST_LOAD: begin
          // A STOP mid-burst is remembered; the burst always finishes.
          if (stop_s) stop_pend_q <= 1'b1;
          if (accept_s) begin
            if (m_addr_q == LAST_CH) begin
              m_write_q <= 1'b0;
              if (stop_pend_q || stop_s) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q     <= ST_DWELL;
                dwell_cnt_q <= dwell_load_s;
              end
            end else begin
              m_addr_q  <= m_addr_q + 4'd1;
              m_wdata_q <= {{PAD_W{1'b0}}, seq_rdata_s};
            end
          end
        end
        ST_DWELL: begin
          if (stop_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (dwell_cnt_q == DWELL_ONE) begin
            if ((idx_q < last_idx_q) || loop_q) begin
              state_q   <= ST_LOAD;
              idx_q     <= wrap_idx_d;
              m_write_q <= 1'b1;
              m_addr_q  <= 4'd0;
              m_wdata_q <= {{PAD_W{1'b0}}, seq_rdata_s};
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              fd_q    <= 1'b1;
              done_q  <= 1'b1;
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_ONE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          m_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Slave read data source.
  always_comb begin
    rd_mux_s = 32'd0;
    if (s_address[7]) begin
      rd_mux_s = {{PAD_W{1'b0}}, cpu_rdata_s};
    end else begin
      case (s_address)
        REG_STATUS:  rd_mux_s = {23'd0, done_q, 1'b0, idx_q, 3'd0, busy_q};
        REG_NUM_PAT: rd_mux_s = {28'd0, num_pat_q};
        REG_DWELL:   rd_mux_s = {{(32 - DWELL_W){1'b0}}, dwell_q};
        default:     rd_mux_s = 32'd0;
      endcase
    end
  end

  // Registered read data, captured on the s_read cycle and held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'd0;
    end else if (s_read) begin
      rdata_q <= rd_mux_s;
    end
  end

  assign s_readdata  = rdata_q;
  assign m_address   = m_addr_q;
  assign m_write     = m_write_q;
  assign m_writedata = m_wdata_q;
  assign seq_busy    = busy_q;
  assign pattern_idx = idx_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_ris_pattern_sequencer.sv
// Scoreboard bench for ris_pattern_sequencer: each run pushes the duty
// writes it should produce (pattern order from NUM_PAT/LOOP rules, data
// from a model copy of pattern memory); a monitor pops on every accepted
// master write. Timing is checked as cycle counts from the START write.
module tb_ris_pattern_sequencer;

  localparam logic [7:0] A_CTRL = 8'h00, A_STATUS = 8'h01, A_NUMPAT = 8'h02, A_DWELL = 8'h03;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [2:0]  idx;
  } exp_t;

  logic        clk, reset;
  logic [7:0]  s_address;
  logic        s_write, s_read;
  logic [31:0] s_writedata, s_readdata;
  logic [3:0]  m_address;
  logic        m_write, m_waitrequest;
  logic [31:0] m_writedata;
  logic        seq_busy, frame_done;
  logic [2:0]  pattern_idx;

  exp_t        exp_q[$];
  logic [15:0] model_mem [8][9];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          fd_count = 0;

  ris_pattern_sequencer dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_write(s_write), .s_writedata(s_writedata),
    .s_read(s_read), .s_readdata(s_readdata),
    .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest),
    .seq_busy(seq_busy), .pattern_idx(pattern_idx), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected write per accepted master write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (frame_done) fd_count++;
        if (m_write && !m_waitrequest) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none", m_address, m_writedata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {28'd0, m_address}, {28'd0, e.addr});
            chk("wr_data", m_writedata, e.data);
            chk("wr_idx", {29'd0, pattern_idx}, {29'd0, e.idx});
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    s_address = a; s_read = 1'b1;
    @(negedge clk);
    s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic pat_wr(input int p, input int ch, input logic [31:0] v);
    wr(8'h80 | 8'(p << 4) | 8'(ch), v);
    model_mem[p][ch] = v[15:0];
  endtask

  task automatic program_random(input int npat);
    for (int p = 0; p < npat; p++)
      for (int ch = 0; ch < 9; ch++)
        pat_wr(p, ch, $urandom);
  endtask

  // Expected writes for n_steps consecutive patterns cycling through npat.
  task automatic push_run(input int npat, input int n_steps);
    for (int j = 0; j < n_steps; j++)
      for (int ch = 0; ch < 9; ch++)
        exp_q.push_back('{addr: 4'(ch), data: {16'd0, model_mem[j % npat][ch]}, idx: 3'(j % npat)});
  endtask

  task automatic wait_fd(input int budget, output int k);
    k = 0;
    while (!frame_done && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_empty(input int budget, output int k);
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    logic [31:0] rdv;
    int k, dw, fd0, drops, tries;
    reset = 1'b1; s_address = 8'd0; s_write = 1'b0; s_writedata = 32'd0;
    s_read = 1'b0; m_waitrequest = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);

    // Reset state
    chk("rst_m_write", {31'd0, m_write}, 32'd0);
    chk("rst_busy", {31'd0, seq_busy}, 32'd0);
    chk("rst_idx", {29'd0, pattern_idx}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_readdata", s_readdata, 32'd0);
    rd(A_STATUS, rdv); chk("rst_status", rdv, 32'd0);

    // Single pattern, DWELL=5, no loop
    for (int ch = 0; ch < 9; ch++) pat_wr(0, ch, 32'h100 + ch);
    wr(A_NUMPAT, 32'd1); wr(A_DWELL, 32'd5);
    push_run(1, 1);
    fd0 = fd_count;
    wr(A_CTRL, 32'h1);
    chk("t1_first_write_next_cycle", {31'd0, m_write}, 32'd1);
    wait_fd(40, k);
    chk("t1_frame_done_cycle", k, 32'd14);
    chk("t1_busy_low_at_done", {31'd0, seq_busy}, 32'd0);
    chk("t1_queue_empty", exp_q.size(), 32'd0);
    cyc(1);
    chk("t1_frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
    chk("t1_fd_count", fd_count - fd0, 32'd1);
    rd(A_STATUS, rdv); chk("t1_status_done", rdv, 32'h100);
    wr(A_STATUS, 32'h100);
    rd(A_STATUS, rdv); chk("t1_status_cleared", rdv, 32'h0);

    // Looping over 3 patterns with random dwell
    dw = $urandom_range(1, 4);
    program_random(3);
    wr(A_NUMPAT, 32'd3); wr(A_DWELL, dw);
    push_run(3, 7);
    fd0 = fd_count; drops = 0;
    wr(A_CTRL, 32'h3);
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
      if (!seq_busy) drops++;
    end
    chk("loop_timing", k, 6 * (9 + dw) + 9);
    chk("loop_busy_held", drops, 32'd0);
    wr(A_CTRL, 32'h4);
    chk("stop_in_dwell_busy", {31'd0, seq_busy}, 32'd0);
    cyc(3);
    chk("loop_no_frame_done", fd_count - fd0, 32'd0);

    // Stall of 4 cycles on ch3, then START-while-busy and STOP in dwell
    program_random(1);
    wr(A_NUMPAT, 32'd1); wr(A_DWELL, 32'd100);
    push_run(1, 1);
    fd0 = fd_count;
    wr(A_CTRL, 32'h1);
    tries = 0;
    while (!(m_write && m_address == 4'd3) && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    chk("stall_reached_ch3", {28'd0, m_address}, 32'd3);
    m_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_addr_stable", {28'd0, m_address}, 32'd3);
      chk("stall_data_stable", m_writedata, {16'd0, model_mem[0][3]});
      chk("stall_write_held", {31'd0, m_write}, 32'd1);
      @(negedge clk);
    end
    m_waitrequest = 1'b0;
    chk("stall_release_addr", {28'd0, m_address}, 32'd3);
    cyc(1);
    chk("stall_next_ch4", {28'd0, m_address}, 32'd4);
    wait_empty(20, k);
    chk("stall_queue_empty", exp_q.size(), 32'd0);
    wr(A_CTRL, 32'h1);
    cyc(3);
    chk("start_while_busy_ignored", {31'd0, seq_busy}, 32'd1);
    wr(A_CTRL, 32'h4);
    chk("stop_dwell_next_cycle", {31'd0, seq_busy}, 32'd0);
    rd(A_STATUS, rdv); chk("stop_no_done", rdv, 32'h0);
    chk("stall_no_frame_done", fd_count - fd0, 32'd0);

    // STOP during ch2 of LOAD: burst completes, then idle
    program_random(2);
    wr(A_NUMPAT, 32'd2); wr(A_DWELL, 32'd3);
    push_run(2, 1);
    fd0 = fd_count;
    wr(A_CTRL, 32'h3);
    tries = 0;
    while (!(m_write && m_address == 4'd2) && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    wr(A_CTRL, 32'h4);
    wait_empty(30, k);
    chk("stop_load_burst_done", exp_q.size(), 32'd0);
    chk("stop_load_idle", {31'd0, seq_busy}, 32'd0);
    cyc(6);
    chk("stop_load_no_frame_done", fd_count - fd0, 32'd0);

    // NUM_PAT=12 clamps to 8, DWELL=0 acts as 1
    program_random(8);
    wr(A_NUMPAT, 32'd12); wr(A_DWELL, 32'd0);
    push_run(8, 8);
    wr(A_CTRL, 32'h1);
    wait_fd(200, k);
    chk("clamp_timing", k, 32'd80);
    chk("clamp_queue_empty", exp_q.size(), 32'd0);

    // NUM_PAT=0 acts as 1
    wr(A_NUMPAT, 32'd0);
    push_run(1, 1);
    wr(A_CTRL, 32'h1);
    wait_fd(40, k);
    chk("numpat0_timing", k, 32'd10);
    chk("numpat0_queue_empty", exp_q.size(), 32'd0);

    // Address map corner cases
    wr(8'h8A, $urandom);
    rd(8'h8A, rdv); chk("ch10_reads_zero", rdv, 32'd0);
    rd(8'h91, rdv); chk("ch10_no_alias", rdv, {16'd0, model_mem[1][1]});
    rd(8'hA7, rdv); chk("pattern_readback", rdv, {16'd0, model_mem[2][7]});
    rd(A_CTRL, rdv); chk("ctrl_reads_zero", rdv, 32'd0);
    rd(8'h05, rdv); chk("unmapped_reads_zero", rdv, 32'd0);
    dw = $urandom;
    wr(A_DWELL, dw);
    rd(A_DWELL, rdv); chk("dwell_readback", rdv, dw & 32'h00FF_FFFF);
    wr(A_CTRL, 32'h5);
    cyc(2);
    chk("start_stop_together_idle", {31'd0, seq_busy}, 32'd0);

    // Reset during LOAD of pattern 1 ch5, then a clean restart
    wr(A_NUMPAT, 32'd2); wr(A_DWELL, 32'd1);
    push_run(2, 2);
    wr(A_CTRL, 32'h1);
    tries = 0;
    while (!(m_write && pattern_idx == 3'd1 && m_address == 4'd5) && tries < 60) begin
      @(negedge clk);
      tries++;
    end
    chk("rst_mid_reached_ch5", {28'd0, m_address}, 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_m_write", {31'd0, m_write}, 32'd0);
    chk("rst_async_busy", {31'd0, seq_busy}, 32'd0);
    chk("rst_async_idx", {29'd0, pattern_idx}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    rd(A_NUMPAT, rdv); chk("rst_numpat_zero", rdv, 32'd0);
    rd(A_DWELL, rdv); chk("rst_dwell_zero", rdv, 32'd0);
    program_random(1);
    push_run(1, 1);
    wr(A_CTRL, 32'h1);
    chk("restart_ch0", {28'd0, m_address}, 32'd0);
    wait_fd(40, k);
    chk("restart_timing", k, 32'd10);
    chk("restart_queue_empty", exp_q.size(), 32'd0);

    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
